game_state_controller: RTL

Central game-flow FSM and the control-side counterpart of the lava wall block. It consumes the lava block's hit_lava_wall and the enemy-hit flag, and produces the signals that block consumes: freeze, speed_boost_pulse and level. It also tracks lives, level completion, respawn and game over. It sits between the input/player logic and every hazard block, and advances only on game_tick (60 Hz).

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_state_controller_if.sv | 31 +++
 rtl/game_state_controller_timer.sv | 30 +++
 rtl/game_state_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow constants: FSM state encoding, screen geometry and level indices.
// Imported by the controller, the lava wall block and the HUD.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_DYING = 3'd2,
      ST_CLEAR = 3'd3,
      ST_OVER  = 3'd4
   } game_state_e;

   localparam int SCREEN_W = 640;

   localparam logic [1:0] LEVEL0 = 2'd0;
   localparam logic [1:0] LEVEL1 = 2'd1;

   // Smallest counter width that can still represent maxVal.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Frame-rate control bus between the game-flow FSM and the player/hazard logic.
interface game_state_controller_if;

   logic       game_tick;
   logic       start_btn;
   logic       hit_lava_wall;
   logic       hit_enemy;
   logic [9:0] player_x;

   logic       freeze;
   logic       speed_boost_pulse;
   logic       respawn_pulse;
   logic [1:0] level;
   logic [1:0] lives;
   logic       game_over;
   logic       game_won;
   logic [2:0] state;

   modport master (
      output game_tick, start_btn, hit_lava_wall, hit_enemy, player_x,
      input  freeze, speed_boost_pulse, respawn_pulse, level, lives,
             game_over, game_won, state
   );

   modport slave (
      input  game_tick, start_btn, hit_lava_wall, hit_enemy, player_x,
      output freeze, speed_boost_pulse, respawn_pulse, level, lives,
             game_over, game_won, state
   );

endinterface

// File: rtl/game_state_controller_timer.sv
// Wrapping up-counter with synchronous load and a terminal-count flag; the caller
// qualifies load and enable with game_tick.
module tick_timer #(
   parameter int WIDTH    = 7,
   parameter int TERMINAL = 89
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;

   assign tc_o = (count_q == WIDTH'(TERMINAL));

   // Load wins over counting; the count wraps to zero on the terminal value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_value_i;
      end else if (en_i) begin
         count_q <= tc_o ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/game_state_controller.sv
// Central game-flow FSM: lives, level progression, death/clear freezes and the
// periodic hazard speed boost, all advanced once per game_tick.
module game_state_controller
   import game_pkg::*;
#(
   parameter int LIVES_INIT         = 3,
   parameter int FREEZE_TICKS       = 90,
   parameter int BOOST_PERIOD_TICKS = 600,
   parameter int GOAL_X             = 620,
   parameter int LEVEL_MAX          = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   game_state_controller_if.slave bus
);

   localparam int FREEZE_W = cntWidth(FREEZE_TICKS - 1);
   localparam int BOOST_W  = cntWidth(BOOST_PERIOD_TICKS - 1);

   game_state_e state_q;
   logic [1:0]  lives_q;
   logic [1:0]  level_q;
   logic        boost_q;
   logic        respawn_q;
   logic        over_q;
   logic        won_q;

   logic death;
   logic goal;
   logic freezeTc;
   logic boostTc;
   logic freezeLoad;
   logic freezeEn;
   logic boostLoad;
   logic boostEn;

   assign death = bus.hit_lava_wall | bus.hit_enemy;
   assign goal  = (bus.player_x >= 10'(GOAL_X));

   // The freeze timer restarts on every PLAY tick so it is already zero on DYING/CLEAR entry;
   // the boost counter sits at zero whenever the player is not in PLAY.
   assign freezeLoad = bus.game_tick && (state_q == ST_PLAY);
   assign freezeEn   = bus.game_tick && ((state_q == ST_DYING) || (state_q == ST_CLEAR));
   assign boostLoad  = bus.game_tick && (state_q != ST_PLAY);
   assign boostEn    = bus.game_tick && (state_q == ST_PLAY);

   tick_timer #(
      .WIDTH    (FREEZE_W),
      .TERMINAL (FREEZE_TICKS - 1)
   ) u_freeze_timer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (freezeLoad),
      .load_value_i ('0),
      .en_i         (freezeEn),
      .tc_o         (freezeTc)
   );

   tick_timer #(
      .WIDTH    (BOOST_W),
      .TERMINAL (BOOST_PERIOD_TICKS - 1)
   ) u_boost_timer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (boostLoad),
      .load_value_i ('0),
      .en_i         (boostEn),
      .tc_o         (boostTc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         lives_q   <= 2'(LIVES_INIT);
         level_q   <= LEVEL0;
         boost_q   <= 1'b0;
         respawn_q <= 1'b0;
         over_q    <= 1'b0;
         won_q     <= 1'b0;
      end else if (bus.game_tick) begin
         boost_q   <= 1'b0;
         respawn_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start_btn) begin
                  state_q <= ST_PLAY;
                  lives_q <= 2'(LIVES_INIT);
                  level_q <= LEVEL0;
                  won_q   <= 1'b0;
               end
            end
            ST_PLAY: begin
               // Losing the last life skips the death freeze entirely.
               if (death) begin
                  if (lives_q == 2'd1) begin
                     lives_q <= 2'd0;
                     state_q <= ST_OVER;
                     over_q  <= 1'b1;
                     won_q   <= 1'b0;
                  end else begin
                     lives_q <= lives_q - 2'd1;
                     state_q <= ST_DYING;
                  end
               end else if (goal) begin
                  state_q <= ST_CLEAR;
               end else if (boostTc) begin
                  boost_q <= 1'b1;
               end
            end
            ST_DYING: begin
               if (freezeTc) begin
                  state_q   <= ST_PLAY;
                  respawn_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (freezeTc) begin
                  if (level_q < 2'(LEVEL_MAX)) begin
                     level_q <= level_q + 2'd1;
                     state_q <= ST_PLAY;
                  end else begin
                     state_q <= ST_OVER;
                     over_q  <= 1'b1;
                     won_q   <= 1'b1;
                  end
               end
            end
            ST_OVER: begin
               if (bus.start_btn) begin
                  state_q <= ST_IDLE;
                  over_q  <= 1'b0;
                  won_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.freeze            = (state_q != ST_PLAY);
   assign bus.speed_boost_pulse = boost_q;
   assign bus.respawn_pulse     = respawn_q;
   assign bus.level             = level_q;
   assign bus.lives             = lives_q;
   assign bus.game_over         = over_q;
   assign bus.game_won          = won_q;
   assign bus.state             = state_q;

endmodule
